// File: rtl/xor_gate_using_mux.sv
// ---------------------------------------------------------------------------
// xor_gate_using_mux
//
// A one-cycle pipelined XOR and parity stage. It is built only from 2:1
// multiplexer cells, so it can be used where the gate library offers muxes
// but no XOR. Each result bit is a mux that selects on a[i] and chooses
// between b[i] and ~b[i]. The even-parity bit comes from a linear chain of
// the same mux cells running over the result bits.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset; clears y, parity and out_valid
//   a          operand A, drives the select of each bit mux
//   b          operand B, drives the true/inverted data legs of each bit mux
//   in_valid   a/b are valid this cycle and are captured on the next edge
//   y          registered a XOR b
//   parity     registered XOR-reduction of y (1 = odd number of ones)
//   out_valid  y/parity were loaded on the previous rising edge
// ---------------------------------------------------------------------------
module xor_gate_using_mux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             parity,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_xor;
    logic             w_parity;

    logic [WIDTH-1:0] r_y;
    logic             r_parity;
    logic             r_outValid;

    // One mux level per bit. A select of 0 passes b unchanged; a select of 1
    // passes the inverted b. This gives the XOR truth table without an XOR
    // operator.
    always_comb begin
        w_xor = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_xor[i] = a[i] ? ~b[i] : b[i];
        end
    end

    // The parity chain uses the same mux cell. Each result bit that is set
    // flips the running parity, and a clear bit passes it through. It is
    // written as a loop over one variable rather than a vector of chained
    // nets, which keeps the chain free of self-referencing vector feedback.
    // For WIDTH=1 the loop body never runs, so parity equals the single
    // result bit.
    always_comb begin
        w_parity = w_xor[0];
        for (int i = 1; i < WIDTH; i++) begin
            w_parity = w_xor[i] ? ~w_parity : w_parity;
        end
    end

    // The output register loads only when the operands are valid. When they
    // are not, y and parity keep the last result and only out_valid drops.
    // Reset clears everything at once, and this discards any operand that
    // was about to be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y        <= '0;
            r_parity   <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_y      <= w_xor;
                r_parity <= w_parity;
            end
        end
    end

    assign y         = r_y;
    assign parity    = r_parity;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_xor_gate_using_mux.sv
// ---------------------------------------------------------------------------
// tb_xor_gate_using_mux
//
// This bench drives three instances of the XOR/parity stage with widths of
// 1, 8 and 16 bits. All three share one clock and one reset. Inputs change
// on the falling edge and outputs are sampled 1 ns after the rising edge.
// Expected results go into a per-instance queue when an operand pair is
// driven, and they are popped when the stage presents its output.
// ---------------------------------------------------------------------------
module tb_xor_gate_using_mux;

    typedef struct packed {
        logic [15:0] y;
        logic        p;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [0:0]  a1, b1, y1;
    logic        iv1, p1, ov1;
    logic [7:0]  a8, b8, y8;
    logic        iv8, p8, ov8;
    logic [15:0] a16, b16, y16;
    logic        iv16, p16, ov16;

    exp_t q1[$];
    exp_t q8[$];
    exp_t q16[$];

    int total;
    int bad;

    xor_gate_using_mux #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
        .y(y1), .parity(p1), .out_valid(ov1)
    );

    xor_gate_using_mux #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
        .y(y8), .parity(p8), .out_valid(ov8)
    );

    xor_gate_using_mux #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(iv16),
        .y(y16), .parity(p16), .out_valid(ov16)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset while the inputs are valid and the clock toggles, and
    // check that the outputs never move. Then release reset between edges
    // and check that nothing changes until the next rising edge captures.
    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        a1 = 1'b1;   b1 = 1'b0;     iv1 = 1'b1;
        a8 = 8'hFF;  b8 = 8'h00;    iv8 = 1'b1;
        a16 = 16'h1234; b16 = 16'h0000; iv16 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (y1 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_y1 got=%0h want=0", y1); end
            total++; if (p1 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_p1 got=%0b want=0", p1); end
            total++; if (ov1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ov1 got=%0b want=0", ov1); end
            total++; if (y8 !== 8'h00) begin bad++; $display("[TB] FAIL reset_y8 got=%0h want=00", y8); end
            total++; if (ov8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ov8 got=%0b want=0", ov8); end
        end
        @(negedge clk);
        iv8 = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        total++; if (y1 !== 1'b0)  begin bad++; $display("[TB] FAIL release_y1 got=%0h want=0", y1); end
        total++; if (ov1 !== 1'b0) begin bad++; $display("[TB] FAIL release_ov1 got=%0b want=0", ov1); end
        e.y = 16'h0001; e.p = 1'b1;
        q1.push_back(e);
        @(posedge clk); #1;
        e = q1.pop_front();
        total++; if (y1 !== e.y[0:0]) begin bad++; $display("[TB] FAIL first_capture_y1 got=%0h want=%0h", y1, e.y[0:0]); end
        total++; if (p1 !== e.p)      begin bad++; $display("[TB] FAIL first_capture_p1 got=%0b want=%0b", p1, e.p); end
        total++; if (ov1 !== 1'b1)    begin bad++; $display("[TB] FAIL first_capture_ov1 got=%0b want=1", ov1); end
        total++; if (ov8 !== 1'b0)    begin bad++; $display("[TB] FAIL idle_ov8 got=%0b want=0", ov8); end
    endtask

    // Run all four operand combinations back to back on the 1-bit instance.
    task automatic test_truth_table();
        exp_t       e;
        logic [1:0] pat;
        for (int k = 0; k < 4; k++) begin
            pat = k[1:0];
            @(negedge clk);
            a1 = pat[1]; b1 = pat[0]; iv1 = 1'b1;
            e.y = {15'b0, a1 ^ b1};
            e.p = a1 ^ b1;
            q1.push_back(e);
            @(posedge clk); #1;
            e = q1.pop_front();
            total++; if (y1 !== e.y[0:0]) begin bad++; $display("[TB] FAIL truth_y a=%0b b=%0b got=%0b want=%0b", pat[1], pat[0], y1, e.y[0:0]); end
            total++; if (p1 !== e.p)      begin bad++; $display("[TB] FAIL truth_p a=%0b b=%0b got=%0b want=%0b", pat[1], pat[0], p1, e.p); end
            total++; if (ov1 !== 1'b1)    begin bad++; $display("[TB] FAIL truth_ov got=%0b want=1", ov1); end
        end
        @(negedge clk);
        iv1 = 1'b0;
    endtask

    // Apply fixed 8-bit vectors with known results. Between the first and
    // second vector, hold the stage with in_valid low and change the
    // operands, then check that the last result stays put.
    task automatic test_vector_and_hold();
        exp_t       e;
        logic [7:0] va[3];
        logic [7:0] vb[3];
        logic [7:0] vy[3];
        logic       vp[3];
        va = '{8'hF0, 8'h01, 8'hFF};
        vb = '{8'hAA, 8'h00, 8'h00};
        vy = '{8'h5A, 8'h01, 8'hFF};
        vp = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a8 = va[k]; b8 = vb[k]; iv8 = 1'b1;
            e.y = {8'h00, vy[k]};
            e.p = vp[k];
            q8.push_back(e);
            @(posedge clk); #1;
            e = q8.pop_front();
            total++; if (y8 !== e.y[7:0]) begin bad++; $display("[TB] FAIL vector_y k=%0d got=%0h want=%0h", k, y8, e.y[7:0]); end
            total++; if (p8 !== e.p)      begin bad++; $display("[TB] FAIL vector_p k=%0d got=%0b want=%0b", k, p8, e.p); end
            total++; if (ov8 !== 1'b1)    begin bad++; $display("[TB] FAIL vector_ov k=%0d got=%0b want=1", k, ov8); end
            if (k == 0) begin
                for (int h = 0; h < 2; h++) begin
                    @(negedge clk);
                    a8 = 8'h00; b8 = 8'h0F; iv8 = 1'b0;
                    @(posedge clk); #1;
                    total++; if (y8 !== 8'h5A) begin bad++; $display("[TB] FAIL hold_y got=%0h want=5a", y8); end
                    total++; if (p8 !== 1'b0)  begin bad++; $display("[TB] FAIL hold_p got=%0b want=0", p8); end
                    total++; if (ov8 !== 1'b0) begin bad++; $display("[TB] FAIL hold_ov got=%0b want=0", ov8); end
                end
            end
        end
    endtask

    // Assert reset between edges while y=FF and another operand pair is
    // waiting to be captured. The outputs must clear at once, and the
    // waiting pair must not come back after reset is released.
    task automatic test_reset_midstream();
        exp_t e;
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h00; iv8 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (y8 !== 8'h00) begin bad++; $display("[TB] FAIL midrst_y got=%0h want=00", y8); end
        total++; if (p8 !== 1'b0)  begin bad++; $display("[TB] FAIL midrst_p got=%0b want=0", p8); end
        total++; if (ov8 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ov got=%0b want=0", ov8); end
        @(posedge clk); #1;
        total++; if (y8 !== 8'h00) begin bad++; $display("[TB] FAIL midrst_held_y got=%0h want=00", y8); end
        @(negedge clk);
        iv8 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (y8 !== 8'h00) begin bad++; $display("[TB] FAIL discard_y got=%0h want=00", y8); end
        total++; if (ov8 !== 1'b0) begin bad++; $display("[TB] FAIL discard_ov got=%0b want=0", ov8); end
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0F; iv8 = 1'b1;
        e.y = 16'h0000; e.p = 1'b0;
        q8.push_back(e);
        @(posedge clk); #1;
        e = q8.pop_front();
        total++; if (y8 !== e.y[7:0]) begin bad++; $display("[TB] FAIL after_rst_y got=%0h want=%0h", y8, e.y[7:0]); end
        total++; if (p8 !== e.p)      begin bad++; $display("[TB] FAIL after_rst_p got=%0b want=%0b", p8, e.p); end
        total++; if (ov8 !== 1'b1)    begin bad++; $display("[TB] FAIL after_rst_ov got=%0b want=1", ov8); end
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    // Drive random operand pairs into the 16-bit instance, one per cycle,
    // with in_valid occasionally dropped. Each result is checked against a
    // behavioural XOR/reduction model one cycle later, and the held value is
    // checked on idle cycles.
    task automatic test_back_to_back();
        exp_t        e;
        logic        v;
        logic [15:0] lastY;
        logic        lastP;
        lastY = 16'h0000;
        lastP = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            v = ($urandom_range(0, 7) != 0);
            iv16 = v;
            if (v) begin
                e.y = a16 ^ b16;
                e.p = ^(a16 ^ b16);
                q16.push_back(e);
            end
            @(posedge clk); #1;
            total++; if (ov16 !== v) begin bad++; $display("[TB] FAIL rand_ov n=%0d got=%0b want=%0b", n, ov16, v); end
            if (v) begin
                e = q16.pop_front();
                lastY = e.y;
                lastP = e.p;
            end
            total++; if (y16 !== lastY) begin bad++; $display("[TB] FAIL rand_y n=%0d got=%0h want=%0h", n, y16, lastY); end
            total++; if (p16 !== lastP) begin bad++; $display("[TB] FAIL rand_p n=%0d got=%0b want=%0b", n, p16, lastP); end
        end
        @(negedge clk);
        iv16 = 1'b0;
        total++; if (q16.size() != 0) begin bad++; $display("[TB] FAIL rand_queue_left got=%0d want=0", q16.size()); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_truth_table();
        test_vector_and_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
